// File: rtl/udp_tx_min_pad.sv
// Zero-pads outgoing 32-bit AXI-Stream frames up to MIN_BYTES (FCS excluded), reports each
// frame's final length and flags malformed tkeep beats. One registered output stage.
module udp_tx_min_pad #(
    parameter int unsigned MIN_BYTES = 60,
    parameter int unsigned LEN_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      s_tdata,
    input  logic [3:0]       s_tkeep,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,
    output logic [31:0]      m_tdata,
    output logic [3:0]       m_tkeep,
    output logic             m_tvalid,
    output logic             m_tlast,
    input  logic             m_tready,
    output logic [LEN_W-1:0] frame_len,
    output logic             frame_len_valid,
    output logic             frame_padded,
    output logic             keep_err
);

    localparam int unsigned CntW = LEN_W + 1;
    localparam logic [CntW-1:0] MinBytes = CntW'(MIN_BYTES);
    localparam logic [CntW-1:0] SatMax = {1'b0, {LEN_W{1'b1}}};

    typedef enum logic [0:0] {StPass, StPad} state_e;

    state_e           state_q;
    logic [LEN_W-1:0] cnt_q;

    logic            load;
    logic            in_acc;
    logic            keep_legal;
    logic [2:0]      pop;
    logic [CntW-1:0] sum_w;
    logic [CntW-1:0] cnt_sum;
    logic [CntW-1:0] cnt_round;
    logic [CntW-1:0] cnt_pad;
    logic [31:0]     masked;

    always_comb begin
        load     = !m_tvalid || m_tready;
        s_tready = !reset && (state_q == StPass) && load;
        in_acc   = s_tvalid && s_tready;

        pop = {2'b00, s_tkeep[0]} + {2'b00, s_tkeep[1]} + {2'b00, s_tkeep[2]}
            + {2'b00, s_tkeep[3]};
        sum_w     = {1'b0, cnt_q} + CntW'(pop);
        cnt_sum   = (sum_w > SatMax) ? SatMax : sum_w;
        cnt_round = (cnt_sum + CntW'(3)) & ~CntW'(3);
        cnt_pad   = {1'b0, cnt_q} + CntW'(4);

        keep_legal = (s_tkeep == 4'b1111) ||
                     (s_tlast && (s_tkeep == 4'b1110 || s_tkeep == 4'b1100 ||
                                  s_tkeep == 4'b1000));

        for (int i = 0; i < 4; i++) begin
            masked[i*8 +: 8] = s_tkeep[i] ? s_tdata[i*8 +: 8] : 8'h00;
        end

        // frame_len is loaded with the tlast beat, so it is already valid during this pulse.
        frame_len_valid = !reset && m_tvalid && m_tready && m_tlast;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StPass;
            cnt_q        <= '0;
            m_tdata      <= '0;
            m_tkeep      <= '0;
            m_tvalid     <= 1'b0;
            m_tlast      <= 1'b0;
            frame_len    <= '0;
            frame_padded <= 1'b0;
            keep_err     <= 1'b0;
        end else begin
            keep_err <= in_acc && !keep_legal;
            if (load) begin
                m_tvalid <= 1'b0;
                unique case (state_q)
                    StPass: begin
                        if (in_acc) begin
                            m_tvalid <= 1'b1;
                            if (!s_tlast) begin
                                m_tdata <= s_tdata;
                                m_tkeep <= s_tkeep;
                                m_tlast <= 1'b0;
                                cnt_q   <= cnt_sum[LEN_W-1:0];
                            end else if (cnt_sum >= MinBytes) begin
                                m_tdata      <= s_tdata;
                                m_tkeep      <= s_tkeep;
                                m_tlast      <= 1'b1;
                                cnt_q        <= '0;
                                frame_len    <= cnt_sum[LEN_W-1:0];
                                frame_padded <= 1'b0;
                            end else begin
                                // Short frame: fill the last beat, then pad if still short.
                                m_tdata      <= masked;
                                m_tkeep      <= 4'b1111;
                                frame_padded <= 1'b1;
                                if (cnt_round >= MinBytes) begin
                                    m_tlast   <= 1'b1;
                                    cnt_q     <= '0;
                                    frame_len <= cnt_round[LEN_W-1:0];
                                end else begin
                                    m_tlast <= 1'b0;
                                    cnt_q   <= cnt_round[LEN_W-1:0];
                                    state_q <= StPad;
                                end
                            end
                        end
                    end
                    StPad: begin
                        m_tvalid <= 1'b1;
                        m_tdata  <= '0;
                        m_tkeep  <= 4'b1111;
                        if (cnt_pad >= MinBytes) begin
                            m_tlast      <= 1'b1;
                            cnt_q        <= '0;
                            frame_len    <= cnt_pad[LEN_W-1:0];
                            frame_padded <= 1'b1;
                            state_q      <= StPass;
                        end else begin
                            m_tlast <= 1'b0;
                            cnt_q   <= cnt_pad[LEN_W-1:0];
                        end
                    end
                    default: state_q <= StPass;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_udp_tx_min_pad.sv
// Randomised bench for udp_tx_min_pad; expected output beats and frame lengths come from a
// frame-level model of the padding rules.
module tb_udp_tx_min_pad;

    localparam int MIN = 60;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic [15:0] frame_len;
    logic        frame_len_valid;
    logic        frame_padded;
    logic        keep_err;

    udp_tx_min_pad #(
        .MIN_BYTES(MIN),
        .LEN_W    (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s_tdata        (s_tdata),
        .s_tkeep        (s_tkeep),
        .s_tvalid       (s_tvalid),
        .s_tlast        (s_tlast),
        .s_tready       (s_tready),
        .m_tdata        (m_tdata),
        .m_tkeep        (m_tkeep),
        .m_tvalid       (m_tvalid),
        .m_tlast        (m_tlast),
        .m_tready       (m_tready),
        .frame_len      (frame_len),
        .frame_len_valid(frame_len_valid),
        .frame_padded   (frame_padded),
        .keep_err       (keep_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        pad_after;
    } beat_t;

    typedef struct packed {
        logic [15:0] len;
        logic        padded;
    } frm_t;

    beat_t cur_q[$];
    beat_t in_q[$];
    beat_t exp_q[$];
    frm_t  len_q[$];

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;
    int valid_prob = 100;
    bit rand_ready = 0;
    bit cont_mode = 0;
    bit started = 0;
    bit acc_in = 0;
    bit exp_kerr = 0;
    bit pad_wait = 0;
    bit stalled_prev = 0;
    logic [37:0] held;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_beat(input logic [31:0] data, input logic [3:0] keep, input logic last);
        beat_t b;
        b.data = data;
        b.keep = keep;
        b.last = last;
        b.pad_after = 1'b0;
        cur_q.push_back(b);
    endtask

    // Frame-level model: short frames get their last beat filled to 4 bytes, then zero
    // beats until MIN bytes; long frames pass through untouched.
    task automatic end_frame();
        int total = 0;
        int r, npad;
        beat_t b, e;
        frm_t f;
        foreach (cur_q[i]) total += $countones(cur_q[i].keep);
        if (total >= MIN) begin
            foreach (cur_q[i]) begin
                in_q.push_back(cur_q[i]);
                exp_q.push_back(cur_q[i]);
            end
            f.len = 16'(total);
            f.padded = 1'b0;
        end else begin
            r = (total + 3) / 4 * 4;
            npad = (r >= MIN) ? 0 : (MIN - r) / 4;
            foreach (cur_q[i]) begin
                b = cur_q[i];
                e = cur_q[i];
                if (b.last) begin
                    b.pad_after = (npad > 0);
                    for (int l = 0; l < 4; l++) if (!b.keep[l]) e.data[l*8 +: 8] = 8'h00;
                    e.keep = 4'hF;
                    e.last = (npad == 0);
                end
                in_q.push_back(b);
                exp_q.push_back(e);
            end
            for (int p = 1; p <= npad; p++) begin
                e = '0;
                e.keep = 4'hF;
                e.last = (p == npad);
                exp_q.push_back(e);
            end
            f.len = 16'((r >= MIN) ? r : MIN);
            f.padded = 1'b1;
        end
        len_q.push_back(f);
        cur_q.delete();
    endtask

    task automatic add_full_frame(input int nbytes);
        int nb = (nbytes + 3) / 4;
        int rem = nbytes - 4 * (nb - 1);
        logic [3:0] k;
        for (int i = 0; i < nb; i++) begin
            k = 4'hF;
            if (i == nb - 1) k = (rem == 1) ? 4'h8 : (rem == 2) ? 4'hC : (rem == 3) ? 4'hE : 4'hF;
            add_beat($urandom, k, (i == nb - 1));
        end
        end_frame();
    endtask

    task automatic add_random_frame();
        int nb = $urandom_range(1, 20);
        logic [3:0] k;
        for (int i = 0; i < nb; i++) begin
            if (i != nb - 1) begin
                k = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
            end else begin
                case ($urandom_range(0, 4))
                    0: k = 4'hF;
                    1: k = 4'hE;
                    2: k = 4'hC;
                    3: k = 4'h8;
                    default: k = 4'($urandom);
                endcase
            end
            add_beat($urandom, k, (i == nb - 1));
        end
        end_frame();
    endtask

    function automatic bit keep_legal(input logic [3:0] k, input logic last);
        return (k == 4'hF) || (last && (k == 4'hE || k == 4'hC || k == 4'h8));
    endfunction

    task automatic step();
        beat_t e;
        frm_t f;
        @(posedge clk);
        #1;
        if (acc_in) void'(in_q.pop_front());
        m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (in_q.size() > 0 && $urandom_range(1, 100) <= valid_prob) begin
            s_tvalid = 1'b1;
            s_tdata  = in_q[0].data;
            s_tkeep  = in_q[0].keep;
            s_tlast  = in_q[0].last;
        end else begin
            s_tvalid = 1'b0;
            s_tdata  = $urandom;
            s_tkeep  = 4'($urandom);
            s_tlast  = 1'b0;
        end
        @(negedge clk);
        check_val("keep_err", keep_err, exp_kerr);
        exp_kerr = 0;
        if (stalled_prev) check_val("stall_hold", {m_tvalid, m_tlast, m_tkeep, m_tdata}, held);
        stalled_prev = m_tvalid && !m_tready;
        held = {m_tvalid, m_tlast, m_tkeep, m_tdata};
        if (m_tvalid && m_tlast) pad_wait = 0;
        if (pad_wait) check_val("pad_s_tready", s_tready, 0);
        if (cont_mode && started && exp_q.size() > 0) check_val("no_bubble", m_tvalid, 1);
        if (m_tvalid && m_tready) begin
            n_out++;
            check_val("beat_expected", 64'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("m_beat", {m_tlast, m_tkeep, m_tdata}, {e.last, e.keep, e.data});
            end
            if (m_tlast) begin
                check_val("frame_expected", 64'(len_q.size() > 0), 1);
                check_val("frame_len_valid", frame_len_valid, 1);
                if (len_q.size() > 0) begin
                    f = len_q.pop_front();
                    check_val("frame_len", frame_len, f.len);
                    check_val("frame_padded", frame_padded, f.padded);
                end
            end else begin
                check_val("frame_len_valid_idle", frame_len_valid, 0);
            end
        end else begin
            check_val("frame_len_valid_idle", frame_len_valid, 0);
        end
        acc_in = s_tvalid && s_tready;
        if (acc_in) begin
            started = 1;
            exp_kerr = !keep_legal(s_tkeep, s_tlast);
            if (s_tlast && in_q.size() > 0 && in_q[0].pad_after) pad_wait = 1;
        end
    endtask

    task automatic run_phase(input bit cont, input bit rready, input int vprob, input int limit);
        cont_mode = cont;
        rand_ready = rready;
        valid_prob = vprob;
        started = 0;
        for (int c = 0; c < limit && (in_q.size() > 0 || exp_q.size() > 0); c++) step();
        check_val("drained", 64'(in_q.size() + exp_q.size()), 0);
    endtask

    initial begin
        reset = 1'b1;
        s_tvalid = 1'b0;
        s_tdata = '0;
        s_tkeep = '0;
        s_tlast = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_state", {s_tready, m_tvalid, m_tlast, m_tkeep, m_tdata, frame_len,
                                  frame_len_valid, frame_padded, keep_err}, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // 60-byte frame, streaming, no padding
        add_full_frame(60);
        run_phase(1, 0, 100, 200);

        // 14-byte frame ending 0xAABBCCDD keep 1100
        add_beat($urandom, 4'hF, 0);
        add_beat($urandom, 4'hF, 0);
        add_beat($urandom, 4'hF, 0);
        add_beat(32'hAABBCCDD, 4'hC, 1);
        end_frame();
        run_phase(1, 0, 100, 200);

        // 59-byte frame: only the last beat is filled
        add_full_frame(59);
        run_phase(1, 0, 100, 200);

        // 61-byte then 4-byte frame back to back
        add_full_frame(61);
        add_full_frame(4);
        run_phase(1, 0, 100, 300);

        // 14-byte frame again under random backpressure
        add_beat($urandom, 4'hF, 0);
        add_beat($urandom, 4'hF, 0);
        add_beat($urandom, 4'hF, 0);
        add_beat(32'hAABBCCDD, 4'hC, 1);
        end_frame();
        run_phase(0, 1, 100, 400);

        // malformed non-last beat
        add_beat($urandom, 4'hF, 0);
        add_beat($urandom, 4'hC, 0);
        add_beat($urandom, 4'hF, 1);
        end_frame();
        run_phase(0, 0, 100, 200);

        // reset while the 5th pad beat of a 14-byte frame is on the output
        n_out = 0;
        add_full_frame(14);
        cont_mode = 0;
        rand_ready = 0;
        valid_prob = 100;
        for (int c = 0; c < 100 && n_out < 8; c++) step();
        @(posedge clk);
        #1;
        reset = 1'b1;
        s_tvalid = 1'b0;
        @(negedge clk);
        check_val("rst_s_tready", s_tready, 0);
        check_val("rst_flv_during", frame_len_valid, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_val("rst_m_tvalid", m_tvalid, 0);
        check_val("rst_flv_after", frame_len_valid, 0);
        in_q.delete();
        exp_q.delete();
        len_q.delete();
        pad_wait = 0;
        acc_in = 0;
        stalled_prev = 0;
        exp_kerr = 0;
        add_full_frame(64);
        run_phase(1, 0, 100, 200);

        // random traffic with backpressure and gaps
        for (int i = 0; i < 30; i++) add_random_frame();
        run_phase(0, 1, 70, 8000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
